lcd_write_engine: RTL
=====================

Name: lcd_write_engine

Overview:
- Sits between the CPU's memory-mapped LCD output register and the HD44780-compatible character LCD pins.
- Software writes {ON, START, RS, DATA} into the LCD register. This block turns each START rising edge into one correctly timed LCD write cycle: RS/DATA setup, EN pulse, hold, then command-execution wait.
- It reports o_busy so software can poll it through an input port.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before EN rises (>=40 ns at 50 MHz).
- EN_CYC, 25: cycles EN is held high (>=450 ns).
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- EXEC_CYC, 2000: post-write wait for normal commands and data (40 us).
- LONG_CYC, 82000: post-write wait for clear/home commands (1.64 ms).
- PWRUP_CYC, 750000: power-on delay, used only with LCD_INIT_EN (15 ms).
- CNT_W, 20: width of the shared delay counter; must hold max(all *_CYC).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lcd_reg  in  32  LCD register from the CPU: [31] ON, [10] START, [9] RS, [7:0] DATA; other bits ignored.
- o_busy  out  1  transaction or init sequence in progress.
- o_lcd_on  out  1  LCD power/backlight enable.
- o_lcd_en  out  1  LCD E strobe.
- o_lcd_rs  out  1  LCD register select.
- o_lcd_rw  out  1  LCD R/W; constant 0 (write only).
- o_lcd_data  out  8  LCD data bus.

Behaviour:
- Reset value of every output is 0; state IDLE; internal latches and counter 0. Reset mid-transaction aborts immediately with EN low.
- o_lcd_on is registered from i_lcd_reg[31], giving 1 cycle latency.
- START edge detect: a registered copy of i_lcd_reg[10]. A request occurs when the current value is 1 and the previous value is 0, with ON=1.
- State machine:
  - IDLE: on a request, latch RS=i_lcd_reg[9] and DATA=i_lcd_reg[7:0] on that same clock edge, then go to SETUP. o_busy rises on that edge.
  - SETUP: EN=0; RS/DATA driven from the latch; stay SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1 for exactly EN_CYC cycles, then HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles, then EXEC.
  - EXEC: wait LONG_CYC cycles if latched RS=0 and DATA[7:1]==7'b0000001 (0x02/0x03, return home) or DATA==0x01 (clear); otherwise wait EXEC_CYC. Then go to IDLE and drop o_busy.
- Total busy time is SETUP_CYC+EN_CYC+HOLD_CYC+(EXEC_CYC or LONG_CYC) cycles.
- o_lcd_rs/o_lcd_data keep the last latched values in IDLE and change only on a new request.
- A START rising edge while o_busy=1 is ignored; no queueing. The edge detector still updates, so a held-high START does not fire later.
- START held high produces exactly one transaction; software must clear and re-set START.
- ON falling to 0 in any non-IDLE state: return to IDLE next cycle, EN=0, o_busy=0.
- The counter loads (N-1) on state entry and decrements to 0. A *_CYC value of 0 is illegal (minimum 1).

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined: after reset, enter INIT_WAIT (o_busy=1) for PWRUP_CYC cycles. Then issue the sequence 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0, each using the full SETUP/PULSE/HOLD/EXEC timing (0x01 uses LONG_CYC). Then go to IDLE.
  - START requests during init are ignored.
  - Init runs regardless of ON; o_lcd_on still follows bit 31.
- Not defined: reset goes directly to IDLE and o_busy=0; software performs init itself.

Test Plan (sim parameters SETUP=2, EN=3, HOLD=1, EXEC=10, LONG=50, PWRUP=20; LCD_INIT_EN off unless stated):
- Reset held, then released with i_lcd_reg=0 -> all outputs 0, o_busy=0.
- Write ON=1, RS=1, DATA=0x41, START 0->1 -> o_busy high for 16 cycles; RS=1 and DATA=0x41 driven from the first busy cycle; EN high exactly 3 cycles starting 2 cycles after busy rises; o_lcd_rw=0 throughout.
- RS=0, DATA=0x01 request -> busy for 56 cycles. RS=0, DATA=0x02 -> 56 cycles. RS=0, DATA=0x38 -> 16 cycles.
- Second START edge 5 cycles into a transaction -> ignored; exactly one EN pulse; busy ends at cycle 16; START held high afterwards -> no new transaction.
- ON dropped to 0 during PULSE -> EN=0 and o_busy=0 on the following cycle. Separately, assert i_rst_n=0 mid-EXEC -> all outputs 0 immediately.
- LCD_INIT_EN defined -> busy from reset for 20 cycles of INIT_WAIT, then five EN pulses with DATA 0x38, 0x38, 0x0C, 0x01, 0x06 (0x01 followed by a 50-cycle wait); a START during init is ignored; o_busy=0 afterwards.

Source files
------------

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: turns START rising edges of the CPU LCD register into timed HD44780 write cycles.
// Define LCD_INIT_EN to run the power-up delay and the init command sequence after reset.
module lcd_write_engine #(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int PWRUP_CYC = 750000,
    parameter int CNT_W     = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    output logic        o_busy,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
`ifdef LCD_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, INIT_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic             in_init;
    logic [2:0]       init_idx;
    logic             req;
    logic             long_cmd;
    logic             last_cmd;
    logic [7:0]       next_cmd;

    assign o_lcd_rw = 1'b0;
    assign req      = i_lcd_reg[10] && !start_q && i_lcd_reg[31];
    // Clear (0x01) and return home (0x02/0x03) need the long execution wait
    assign long_cmd = !o_lcd_rs && (o_lcd_data[7:1] == 7'b0000001 || o_lcd_data == 8'h01);
    assign last_cmd = init_idx == 3'd5;
    assign next_cmd = init_idx == 3'd0 ? 8'h38 :
                      init_idx == 3'd1 ? 8'h38 :
                      init_idx == 3'd2 ? 8'h0C :
                      init_idx == 3'd3 ? 8'h01 : 8'h06;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= INIT_EN ? INIT_WAIT : IDLE;
            cnt        <= INIT_EN ? PWRUP_LD : '0;
            o_busy     <= INIT_EN;
            in_init    <= INIT_EN;
            init_idx   <= '0;
            start_q    <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= '0;
        end else begin
            start_q  <= i_lcd_reg[10];
            o_lcd_on <= i_lcd_reg[31];
            if (state != IDLE && !in_init && !i_lcd_reg[31]) begin
                state    <= IDLE;
                cnt      <= '0;
                o_lcd_en <= 1'b0;
                o_busy   <= 1'b0;
            end else if (state == IDLE) begin
                if (req) begin
                    state      <= SETUP;
                    cnt        <= SETUP_LD;
                    o_busy     <= 1'b1;
                    o_lcd_rs   <= i_lcd_reg[9];
                    o_lcd_data <= i_lcd_reg[7:0];
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                case (state)
                    INIT_WAIT, EXEC: begin
                        if (in_init && !last_cmd) begin
                            state      <= SETUP;
                            cnt        <= SETUP_LD;
                            o_lcd_rs   <= 1'b0;
                            o_lcd_data <= next_cmd;
                            init_idx   <= init_idx + 3'd1;
                        end else begin
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                            in_init <= 1'b0;
                        end
                    end
                    SETUP: begin
                        state    <= PULSE;
                        cnt      <= EN_LD;
                        o_lcd_en <= 1'b1;
                    end
                    PULSE: begin
                        state    <= HOLD;
                        cnt      <= HOLD_LD;
                        o_lcd_en <= 1'b0;
                    end
                    HOLD: begin
                        state <= EXEC;
                        cnt   <= long_cmd ? LONG_LD : EXEC_LD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
